result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer_pkg.sv | 29 ++
 rtl/result_buffer.sv | 65 ++++++
 rtl/result_serializer.sv | 108 ++++++++++
 tb/tb_result_serializer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_serializer_pkg.sv
// Shared defaults, FSM encoding and width helpers for the result serializer.
// Imported by result_buffer and result_serializer.
package result_serializer_pkg;

   localparam int D_WIDTH_DEF   = 32;
   localparam int M_SIZE_DEF    = 2;
   localparam int BUF_DEPTH_DEF = 2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Index registers need at least one bit even for a single-word vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/result_buffer.sv
// Circular store of whole result vectors with their last flags.
// Head entry stays put until the serializer releases it.
module result_buffer
   import result_serializer_pkg::*;
#(
   parameter int E_WIDTH = 65,
   parameter int DEPTH   = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  wr_en,
   input  logic [E_WIDTH-1:0]    wr_data,
   input  logic                  rd_en,
   output logic [E_WIDTH-1:0]    rd_data,
   output logic                  wr_ready,
   output logic [clog2(DEPTH):0] count
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [E_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count_next;

   // Occupancy after this edge; accept plus release cancels out.
   always_comb begin
      count_next = count;
      unique case ({wr_en, rd_en})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Payload storage; stale entries are harmless once occupancy is cleared.
   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and the registered ready flag.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wr_ready <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count    <= count_next;
         wr_ready <= (count_next < CW'(DEPTH));
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/result_serializer.sv
// Splits buffered result vectors into an AXI-Stream word sequence.
// The head vector is held in the buffer until its final word leaves.
module result_serializer
   import result_serializer_pkg::*;
#(
   parameter int D_WIDTH   = D_WIDTH_DEF,
   parameter int M_SIZE    = M_SIZE_DEF,
   parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        s_result_valid,
   input  logic                        s_result_last,
   input  logic [D_WIDTH*M_SIZE-1:0]   s_result_data,
   output logic                        s_result_ready,
   output logic [D_WIDTH-1:0]          m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        o_busy
);

   localparam int VW = D_WIDTH * M_SIZE;
   localparam int EW = VW + 1;
   localparam int IW = idx_width(M_SIZE);
   localparam int CW = clog2(BUF_DEPTH) + 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(M_SIZE - 1);

   logic [0:0]         state;
   logic [0:0]         state_next;
   logic [IW-1:0]      idx;
   logic [EW-1:0]      head;
   logic [CW-1:0]      count;
   logic [D_WIDTH-1:0] word;
   logic               buf_ready;
   logic               wr_en;
   logic               rd_en;
   logic               xfer;
   logic               last_word;

   assign wr_en     = s_result_valid & buf_ready;
   assign xfer      = m_axis_tvalid & m_axis_tready;
   assign last_word = (idx == LAST_IDX);
   assign rd_en     = xfer & last_word;

   result_buffer #(
      .E_WIDTH (EW),
      .DEPTH   (BUF_DEPTH)
   ) u_buf (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .wr_en    (wr_en),
      .wr_data  ({s_result_last, s_result_data}),
      .rd_en    (rd_en),
      .rd_data  (head),
      .wr_ready (buf_ready),
      .count    (count)
   );

   // Next state tracks whether any vector remains stored after this edge.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: begin
            if (wr_en) begin
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            if (rd_en && !wr_en && count == CW'(1)) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State and word index; index wraps as the head vector is released.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_next;
         if (xfer) begin
            idx <= last_word ? '0 : idx + IW'(1);
         end
      end
   end

   // Select the current word of the head vector.
   always_comb begin
      word = '0;
      for (int k = 0; k < M_SIZE; k++) begin
         if (idx == IW'(k)) begin
            word = head[k*D_WIDTH +: D_WIDTH];
         end
      end
   end

   assign m_axis_tvalid  = (state == ST_SEND);
   assign m_axis_tdata   = m_axis_tvalid ? word : '0;
   assign m_axis_tlast   = m_axis_tvalid & last_word & head[VW];
   assign s_result_ready = buf_ready;
   assign o_busy         = (count != '0) | m_axis_tvalid;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_result_serializer;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        s_result_valid = 1'b0;
   logic        s_result_last = 1'b0;
   logic [63:0] s_result_data = '0;
   logic        s_result_ready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic        o_busy;

   int n_assert = 0;
   int n_fail = 0;

   result_serializer #(
      .D_WIDTH   (32),
      .M_SIZE    (2),
      .BUF_DEPTH (2)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_result_valid (s_result_valid),
      .s_result_last  (s_result_last),
      .s_result_data  (s_result_data),
      .s_result_ready (s_result_ready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .o_busy         (o_busy)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic offer(input logic v, input logic l,
                        input logic [31:0] w1, input logic [31:0] w0);
      s_result_valid = v;
      s_result_last  = l;
      s_result_data  = {w1, w0};
   endtask

   task automatic expect_word(input string tag, input logic [31:0] w,
                              input logic l);
      check({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd1);
      check({tag, ".tdata"}, 64'(m_axis_tdata), 64'(w));
      check({tag, ".tlast"}, 64'(m_axis_tlast), 64'(l));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, ".busy"}, 64'(o_busy), 64'd0);
      check({tag, ".ready"}, 64'(s_result_ready), 64'd1);
   endtask

   task automatic expect_reset(input string tag);
      check({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, ".tlast"}, 64'(m_axis_tlast), 64'd0);
      check({tag, ".tdata"}, 64'(m_axis_tdata), 64'd0);
      check({tag, ".ready"}, 64'(s_result_ready), 64'd0);
      check({tag, ".busy"}, 64'(o_busy), 64'd0);
   endtask

   initial begin
      logic        acc;
      int          v;
      int          n;
      int          nlast;
      logic [31:0] ew;

      // reset state
      repeat (2) @(negedge aclk);
      expect_reset("rst_hold");
      aresetn = 1'b1;
      check("rst_rel_ready", 64'(s_result_ready), 64'd0);
      @(negedge aclk);
      expect_idle("rst_after");

      // single vector, tready high
      m_axis_tready = 1'b1;
      offer(1'b1, 1'b1, 32'h4140_0000, 32'h4040_0000);
      check("t1_tvalid_pre", 64'(m_axis_tvalid), 64'd0);
      @(negedge aclk);
      offer(1'b0, 1'b0, '0, '0);
      expect_word("t1_w0", 32'h4040_0000, 1'b0);
      check("t1_busy", 64'(o_busy), 64'd1);
      @(negedge aclk);
      expect_word("t1_w1", 32'h4140_0000, 1'b1);
      @(negedge aclk);
      expect_idle("t1_end");

      // three vectors against a stalled sink
      m_axis_tready = 1'b0;
      offer(1'b1, 1'b0, 32'hA000_0001, 32'hA000_0000);
      check("t2_rdy_a", 64'(s_result_ready), 64'd1);
      @(negedge aclk);
      offer(1'b1, 1'b0, 32'hB000_0001, 32'hB000_0000);
      check("t2_rdy_b", 64'(s_result_ready), 64'd1);
      expect_word("t2_a0_stall", 32'hA000_0000, 1'b0);
      @(negedge aclk);
      offer(1'b1, 1'b1, 32'hC000_0001, 32'hC000_0000);
      check("t2_rdy_full", 64'(s_result_ready), 64'd0);
      expect_word("t2_a0_hold", 32'hA000_0000, 1'b0);
      m_axis_tready = 1'b1;
      @(negedge aclk);
      check("t2_rdy_full2", 64'(s_result_ready), 64'd0);
      expect_word("t2_a1", 32'hA000_0001, 1'b0);
      @(negedge aclk);
      check("t2_rdy_free", 64'(s_result_ready), 64'd1);
      expect_word("t2_b0", 32'hB000_0000, 1'b0);
      @(negedge aclk);
      offer(1'b0, 1'b0, '0, '0);
      expect_word("t2_b1", 32'hB000_0001, 1'b0);
      @(negedge aclk);
      expect_word("t2_c0", 32'hC000_0000, 1'b0);
      @(negedge aclk);
      expect_word("t2_c1", 32'hC000_0001, 1'b1);
      @(negedge aclk);
      expect_idle("t2_end");

      // stall pattern 1,0,0,1 across the vector
      offer(1'b1, 1'b1, 32'hD000_0001, 32'hD000_0000);
      @(negedge aclk);
      offer(1'b0, 1'b0, '0, '0);
      expect_word("t3_d0", 32'hD000_0000, 1'b0);
      @(negedge aclk);
      expect_word("t3_d1", 32'hD000_0001, 1'b1);
      m_axis_tready = 1'b0;
      @(negedge aclk);
      expect_word("t3_d1_s1", 32'hD000_0001, 1'b1);
      @(negedge aclk);
      expect_word("t3_d1_s2", 32'hD000_0001, 1'b1);
      m_axis_tready = 1'b1;
      @(negedge aclk);
      expect_idle("t3_end");

      // accept on the final-word release edge
      offer(1'b1, 1'b0, 32'hE000_0001, 32'hE000_0000);
      @(negedge aclk);
      offer(1'b0, 1'b0, '0, '0);
      expect_word("t4_e0", 32'hE000_0000, 1'b0);
      @(negedge aclk);
      expect_word("t4_e1", 32'hE000_0001, 1'b0);
      offer(1'b1, 1'b1, 32'hF000_0001, 32'hF000_0000);
      check("t4_rdy", 64'(s_result_ready), 64'd1);
      @(negedge aclk);
      offer(1'b0, 1'b0, '0, '0);
      expect_word("t4_f0", 32'hF000_0000, 1'b0);
      check("t4_rdy_occ1", 64'(s_result_ready), 64'd1);
      @(negedge aclk);
      expect_word("t4_f1", 32'hF000_0001, 1'b1);
      @(negedge aclk);
      expect_idle("t4_end");

      // reset after word 0 of a stored vector
      offer(1'b1, 1'b1, 32'h5000_0001, 32'h5000_0000);
      @(negedge aclk);
      offer(1'b0, 1'b0, '0, '0);
      expect_word("t5_g0", 32'h5000_0000, 1'b0);
      @(negedge aclk);
      expect_word("t5_g1", 32'h5000_0001, 1'b1);
      m_axis_tready = 1'b0;
      #2 aresetn = 1'b0;
      #1 expect_reset("t5_async");
      @(negedge aclk);
      aresetn = 1'b1;
      check("t5_rel_ready", 64'(s_result_ready), 64'd0);
      m_axis_tready = 1'b1;
      @(negedge aclk);
      expect_idle("t5_after");
      repeat (3) begin
         @(negedge aclk);
         check("t5_no_stale", 64'(m_axis_tvalid), 64'd0);
      end

      // four vectors, last only on the fourth
      acc = 1'b0;
      v = 0;
      n = 0;
      nlast = 0;
      repeat (30) begin
         @(negedge aclk);
         if (acc) v++;
         if (v < 4) begin
            offer(1'b1, (v == 3), 32'h9000_0000 + 32'(v * 16 + 1),
                  32'h9000_0000 + 32'(v * 16));
         end else begin
            offer(1'b0, 1'b0, '0, '0);
         end
         acc = s_result_valid && s_result_ready;
         if (m_axis_tvalid) begin
            ew = 32'h9000_0000 + 32'((n / 2) * 16 + (n % 2));
            check($sformatf("t6_w%0d.tdata", n), 64'(m_axis_tdata), 64'(ew));
            check($sformatf("t6_w%0d.tlast", n), 64'(m_axis_tlast),
                  64'(n == 7));
            if (m_axis_tlast) nlast++;
            n++;
         end
      end
      check("t6_vectors", 64'(v), 64'd4);
      check("t6_words", 64'(n), 64'd8);
      check("t6_tlast_count", 64'(nlast), 64'd1);
      expect_idle("t6_end");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
